fir_transposed_cfg: RTL and testbench

- Parametrised successor to the team's fixed-tap pipelined FIR: a transposed-form FIR with runtime-reloadable coefficients.
- Adds a valid-qualified sample stream (gaps allowed), a double-buffered coefficient bank with atomic commit, and output rounding/saturation to a narrower output width.
- Sits between the sample source and downstream decimation/processing.
- Fixed 2-cycle latency, sample-indexed behaviour independent of input gaps.

---
 rtl/fir_transposed_cfg_if.sv | 30 +++
 rtl/fir_transposed_cfg.sv | 131 +++++++++++++
 tb/tb_fir_transposed_cfg.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/fir_transposed_cfg_if.sv
// Sample, coefficient-load and filtered-output signals of fir_transposed_cfg.
// The master side is the sample source / coefficient loader. The slave side is the filter.
interface fir_transposed_cfg_if #(
  parameter int DATA_IN_WIDTH  = 16,
  parameter int TAP_WIDTH      = 16,
  parameter int TAP_COUNT      = 8,
  parameter int DATA_OUT_WIDTH = 32
);
  localparam int ADDR_WIDTH = $clog2(TAP_COUNT);

  logic                             in_valid;
  logic signed [DATA_IN_WIDTH-1:0]  in_data;
  logic                             coef_wr_en;
  logic        [ADDR_WIDTH-1:0]     coef_addr;
  logic signed [TAP_WIDTH-1:0]      coef_data;
  logic                             coef_commit;
  logic                             out_valid;
  logic signed [DATA_OUT_WIDTH-1:0] out_data;
  logic                             out_sat;

  modport master (
    output in_valid, in_data, coef_wr_en, coef_addr, coef_data, coef_commit,
    input  out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, coef_wr_en, coef_addr, coef_data, coef_commit,
    output out_valid, out_data, out_sat
  );
endinterface

// File: rtl/fir_transposed_cfg.sv
// Transposed-form FIR filter with a double-buffered coefficient bank.
// The filter accepts a valid-qualified sample stream and has a fixed latency of 2 cycles.
// It rounds, then saturates, the accumulator into a narrower signed output.
module fir_transposed_cfg #(
  parameter int DATA_IN_WIDTH  = 16,
  parameter int TAP_WIDTH      = 16,
  parameter int TAP_COUNT      = 8,
  parameter int ACC_WIDTH      = DATA_IN_WIDTH + TAP_WIDTH + $clog2(TAP_COUNT),
  parameter int OUT_SHIFT      = 0,
  parameter int DATA_OUT_WIDTH = 32,
  parameter logic [TAP_COUNT-1:0][TAP_WIDTH-1:0] INIT_TAPS = '0
) (
  input logic                 clk,
  input logic                 reset,
  fir_transposed_cfg_if.slave bus
);
  localparam int RND_WIDTH = ACC_WIDTH + 1;

  typedef logic signed [TAP_WIDTH-1:0] tap_t;
  typedef logic signed [ACC_WIDTH-1:0] acc_t;
  typedef logic signed [RND_WIDTH-1:0] rnd_t;

  tap_t shadow_q   [TAP_COUNT];
  tap_t active_q   [TAP_COUNT];
  tap_t shadow_nxt [TAP_COUNT];
  acc_t prod       [TAP_COUNT];
  acc_t p_q        [TAP_COUNT];
  acc_t s_q        [1:TAP_COUNT-1];
  logic p_valid;
  acc_t acc;
  rnd_t rnd;
  logic signed [DATA_OUT_WIDTH-1:0] out_nxt;
  logic sat_nxt;

  // Shadow bank after this cycle's write, so a same-cycle commit picks up the write.
  always_comb begin
    // NOTE: default the whole array first so that no path leaves it unassigned (which would infer a latch).
    shadow_nxt = shadow_q;
    if (bus.coef_wr_en && (int'(bus.coef_addr) < TAP_COUNT))
      shadow_nxt[bus.coef_addr] = bus.coef_data;
  end

  // Coefficient banks: writes go to the shadow bank, and a commit copies the shadow bank to the active bank atomically.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments, so every register samples pre-edge values.
    if (reset) begin
      // NOTE: these small register banks are reset (not left as RAM) because both banks must come back to INIT_TAPS.
      for (int k = 0; k < TAP_COUNT; k++) begin
        shadow_q[k] <= tap_t'(INIT_TAPS[k]);
        active_q[k] <= tap_t'(INIT_TAPS[k]);
      end
    end else begin
      shadow_q <= shadow_nxt;
      if (bus.coef_commit)
        active_q <= shadow_nxt;
    end
  end

  // Full-precision products, computed against the currently active bank.
  always_comb begin
    for (int k = 0; k < TAP_COUNT; k++)
      prod[k] = acc_t'(bus.in_data) * acc_t'(active_q[k]);
  end

  // Stage 1: register the products of each accepted sample, and hold them through gaps.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_valid <= 1'b0;
      for (int k = 0; k < TAP_COUNT; k++)
        p_q[k] <= '0;
    end else begin
      p_valid <= bus.in_valid;
      if (bus.in_valid)
        p_q <= prod;
    end
  end

  assign acc = p_q[0] + s_q[1];

  // Rounding: add half an LSB of the shifted result, then shift arithmetically (round half toward +inf).
  generate
    if (OUT_SHIFT > 0) begin : g_round
      localparam rnd_t HALF = rnd_t'(1) <<< (OUT_SHIFT - 1);
      assign rnd = (rnd_t'(acc) + HALF) >>> OUT_SHIFT;
    end else begin : g_no_round
      assign rnd = rnd_t'(acc);
    end
  endgenerate

  // Saturation into the output width. A wide enough output only needs sign extension.
  generate
    if (DATA_OUT_WIDTH >= ACC_WIDTH) begin : g_wide
      assign out_nxt = DATA_OUT_WIDTH'(rnd);
      assign sat_nxt = 1'b0;
    end else begin : g_sat
      localparam rnd_t SAT_MAX = {{(RND_WIDTH-DATA_OUT_WIDTH+1){1'b0}}, {(DATA_OUT_WIDTH-1){1'b1}}};
      localparam rnd_t SAT_MIN = {{(RND_WIDTH-DATA_OUT_WIDTH+1){1'b1}}, {(DATA_OUT_WIDTH-1){1'b0}}};
      always_comb begin
        out_nxt = DATA_OUT_WIDTH'(rnd);
        sat_nxt = 1'b0;
        if (rnd > SAT_MAX) begin
          out_nxt = {1'b0, {(DATA_OUT_WIDTH-1){1'b1}}};
          sat_nxt = 1'b1;
        end else if (rnd < SAT_MIN) begin
          out_nxt = {1'b1, {(DATA_OUT_WIDTH-1){1'b0}}};
          sat_nxt = 1'b1;
        end
      end
    end
  endgenerate

  // Stage 2: advance the transposed partial-sum chain and register the output, only for valid products.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 1; k < TAP_COUNT; k++)
        s_q[k] <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sat   <= 1'b0;
    end else begin
      bus.out_valid <= p_valid;
      if (p_valid) begin
        for (int k = 1; k < TAP_COUNT - 1; k++)
          s_q[k] <= p_q[k] + s_q[k+1];
        s_q[TAP_COUNT-1] <= p_q[TAP_COUNT-1];
        bus.out_data     <= out_nxt;
        bus.out_sat      <= sat_nxt;
      end
    end
  end
endmodule

// File: tb/tb_fir_transposed_cfg.sv
// Directed bench for fir_transposed_cfg. Three instances share one clock and reset:
//   a: 4 taps {1,2,3,4}, no shift, 32-bit output (streaming, gaps, commit, reset)
//   s: 4 taps {2,2,0,0}, 16-bit output (saturation)
//   r: 4 taps {1,0,0,0}, shift 2 (rounding)
module tb_fir_transposed_cfg;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  typedef struct {
    int                 c;
    logic signed [31:0] d;
    logic               s;
  } obs_t;

  obs_t qa[$], qs[$], qr[$];
  int   in_cyc_q[$];

  fir_transposed_cfg_if #(.DATA_IN_WIDTH(16), .TAP_WIDTH(16), .TAP_COUNT(4), .DATA_OUT_WIDTH(32)) bus_a ();
  fir_transposed_cfg_if #(.DATA_IN_WIDTH(16), .TAP_WIDTH(16), .TAP_COUNT(4), .DATA_OUT_WIDTH(16)) bus_s ();
  fir_transposed_cfg_if #(.DATA_IN_WIDTH(16), .TAP_WIDTH(16), .TAP_COUNT(4), .DATA_OUT_WIDTH(32)) bus_r ();

  fir_transposed_cfg #(
    .TAP_COUNT(4), .OUT_SHIFT(0), .DATA_OUT_WIDTH(32),
    .INIT_TAPS({16'sd4, 16'sd3, 16'sd2, 16'sd1})
  ) dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));

  fir_transposed_cfg #(
    .TAP_COUNT(4), .OUT_SHIFT(0), .DATA_OUT_WIDTH(16),
    .INIT_TAPS({16'sd0, 16'sd0, 16'sd2, 16'sd2})
  ) dut_s (.clk(clk), .reset(reset), .bus(bus_s.slave));

  fir_transposed_cfg #(
    .TAP_COUNT(4), .OUT_SHIFT(2), .DATA_OUT_WIDTH(32),
    .INIT_TAPS({16'sd0, 16'sd0, 16'sd0, 16'sd1})
  ) dut_r (.clk(clk), .reset(reset), .bus(bus_r.slave));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every valid output with the cycle it appeared in
  always @(negedge clk) begin
    if (bus_a.out_valid) qa.push_back('{c: cyc, d: 32'(bus_a.out_data), s: bus_a.out_sat});
    if (bus_s.out_valid) qs.push_back('{c: cyc, d: 32'(bus_s.out_data), s: bus_s.out_sat});
    if (bus_r.out_valid) qr.push_back('{c: cyc, d: 32'(bus_r.out_data), s: bus_r.out_sat});
  end

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle_all();
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.coef_wr_en = 1'b0;
    bus_a.coef_addr = '0;  bus_a.coef_data = '0; bus_a.coef_commit = 1'b0;
    bus_s.in_valid = 1'b0; bus_s.in_data = '0; bus_s.coef_wr_en = 1'b0;
    bus_s.coef_addr = '0;  bus_s.coef_data = '0; bus_s.coef_commit = 1'b0;
    bus_r.in_valid = 1'b0; bus_r.in_data = '0; bus_r.coef_wr_en = 1'b0;
    bus_r.coef_addr = '0;  bus_r.coef_data = '0; bus_r.coef_commit = 1'b0;
  endtask

  // One cycle of stimulus on instance `which` (0=a, 1=s, 2=r); all inputs return to idle afterwards
  task automatic drive(input int which, input logic v, input logic signed [15:0] d,
                       input logic we = 1'b0, input logic [1:0] adr = 2'd0,
                       input logic signed [15:0] cd = 16'sd0, input logic cm = 1'b0);
    if (v) in_cyc_q.push_back(cyc);
    case (which)
      0: begin
        bus_a.in_valid = v; bus_a.in_data = d; bus_a.coef_wr_en = we;
        bus_a.coef_addr = adr; bus_a.coef_data = cd; bus_a.coef_commit = cm;
      end
      1: begin bus_s.in_valid = v; bus_s.in_data = d; end
      default: begin bus_r.in_valid = v; bus_r.in_data = d; end
    endcase
    @(posedge clk); #1;
    idle_all();
  endtask

  task automatic clear_obs();
    qa.delete(); qs.delete(); qr.delete(); in_cyc_q.delete();
  endtask

  // Compare recorded outputs with expected data (and sat flags when given), each 2 cycles after its input
  task automatic check_stream(input string tag, input int which, input int exp_d[$], input int exp_s[$]);
    obs_t q[$];
    case (which)
      0:       q = qa;
      1:       q = qs;
      default: q = qr;
    endcase
    check($sformatf("%s_count", tag), q.size(), exp_d.size());
    for (int i = 0; i < exp_d.size() && i < q.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), q[i].d, exp_d[i]);
      if (i < in_cyc_q.size())
        check($sformatf("%s_lat%0d", tag, i), q[i].c, in_cyc_q[i] + 2);
      if (i < exp_s.size())
        check($sformatf("%s_sat%0d", tag, i), q[i].s, exp_s[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int no_sat[$];
    no_sat = {};
    idle_all();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    check("rst_out_valid", bus_a.out_valid, 0);
    check("rst_out_data", bus_a.out_data, 0);
    check("rst_out_sat", bus_s.out_sat, 0);

    // Impulse with back-to-back zeros
    clear_obs();
    drive(0, 1, 1);
    repeat (6) drive(0, 1, 0);
    repeat (4) drive(0, 0, 0);
    check_stream("impulse", 0, '{1, 2, 3, 4, 0, 0, 0}, no_sat);

    // Same samples separated by 3 idle cycles each
    clear_obs();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, (i == 0) ? 16'sd1 : 16'sd0);
      repeat (3) drive(0, 0, 0);
    end
    check_stream("gaps", 0, '{1, 2, 3, 4}, no_sat);

    // Shadow load while streaming, commit alongside an impulse, then write+commit in the same cycle
    clear_obs();
    drive(0, 1, 1, 1, 2'd0, 16'sd5, 0);
    drive(0, 1, 0, 1, 2'd1, 16'sd0, 0);
    drive(0, 1, 0, 1, 2'd2, 16'sd0, 0);
    drive(0, 1, 0, 1, 2'd3, -16'sd1, 0);
    drive(0, 1, 1, 0, 2'd0, 16'sd0, 1);
    repeat (3) drive(0, 1, 0);
    drive(0, 1, 1);
    repeat (3) drive(0, 1, 0);
    drive(0, 1, 0, 1, 2'd1, 16'sd7, 1);
    drive(0, 1, 1);
    repeat (3) drive(0, 1, 0);
    repeat (3) drive(0, 0, 0);
    check_stream("commit", 0, '{1, 2, 3, 4, 1, 2, 3, 4, 5, 0, 0, -1, 0, 5, 7, 0, -1}, no_sat);

    // Saturation into a 16-bit output
    clear_obs();
    drive(1, 1, 32767);
    drive(1, 1, 32767);
    drive(1, 1, -32768);
    drive(1, 1, -32768);
    drive(1, 1, 0);
    drive(1, 1, 0);
    drive(1, 1, 100);
    drive(1, 1, 0);
    repeat (3) drive(1, 0, 0);
    check_stream("sat", 1, '{32767, 32767, -2, -32768, -32768, 0, 200, 200},
                 '{1, 1, 0, 1, 1, 0, 0, 0});

    // Round half toward +inf with a shift of 2
    clear_obs();
    drive(2, 1, 6);
    drive(2, 1, 5);
    drive(2, 1, -6);
    drive(2, 1, -7);
    drive(2, 1, 2);
    drive(2, 1, -2);
    repeat (3) drive(2, 0, 0);
    check_stream("round", 2, '{2, 1, -1, -2, 1, 0}, '{0, 0, 0, 0, 0, 0});

    // Disturb both banks, then reset mid-stream one cycle after an impulse
    drive(0, 0, 0, 1, 2'd0, 16'sd9, 1);
    drive(0, 0, 0, 1, 2'd1, 16'sd9, 0);
    clear_obs();
    drive(0, 1, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_out_data", bus_a.out_data, 0);
    repeat (5) drive(0, 0, 0);
    check("midrst_no_valid", qa.size(), 0);

    // Commit with no writes: the shadow bank must also be back at the initial taps
    clear_obs();
    drive(0, 0, 0, 0, 2'd0, 16'sd0, 1);
    drive(0, 1, 1);
    repeat (4) drive(0, 1, 0);
    repeat (3) drive(0, 0, 0);
    check_stream("post_rst", 0, '{1, 2, 3, 4, 0}, no_sat);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
